// File: rtl/limber_gnrl_fifo_if.sv
// Valid/ready handshake bundle for limber_gnrl_fifo: producer side (i_*) and consumer side (o_*).
// The master modport belongs to the environment that drives both ends; the FIFO takes the slave modport.
interface limber_gnrl_fifo_if #(
  parameter int DW = 8
);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/limber_gnrl_fifo.sv
// Generic synchronous FIFO with valid/ready on both ends and no write-to-read bypass.
// Pointers, count and flags are reset; the storage array is load-enable only.
module limber_gnrl_fifo #(
  parameter int DP = 4,
  parameter int DW = 8,
  localparam int CW = $clog2(DP + 1),
  localparam int PW = (DP > 1) ? $clog2(DP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  limber_gnrl_fifo_if.slave fifo,
  output logic [CW-1:0]     cnt
);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  // Wrap at DP-1 explicitly so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt_q == CW'(DP));
  assign empty = (cnt_q == '0);
  assign push  = fifo.i_vld & ~full;
  assign pop   = fifo.o_rdy & ~empty;

  assign fifo.i_rdy = ~full;
  assign fifo.o_vld = ~empty;
  assign cnt        = cnt_q;

  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DP; e++) begin
      if (push && (wptr_q == PW'(e))) mem_q[e] <= fifo.i_dat;
    end
  end

  // Head read is a plain mux off the registered array, hence one cycle of push-to-pop latency.
  always_comb begin
    fifo.o_dat = '0;
    for (int e = 0; e < DP; e++) begin
      if (rptr_q == PW'(e)) fifo.o_dat = mem_q[e];
    end
  end

  a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo.i_vld && !fifo.i_rdy) |=> (fifo.i_vld && $stable(fifo.i_dat)))
    else $error("producer dropped or changed i_vld/i_dat before i_rdy");

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo.o_vld && !fifo.o_rdy) |=> fifo.o_vld)
    else $error("o_vld dropped without a pop");

endmodule

// File: tb/tb_limber_gnrl_fifo.sv
// Scoreboard bench for limber_gnrl_fifo: a DP=4 instance for directed scenarios and a DP=3 instance
// for wrap with stalls; per-instance monitors compare flags, count and head data against a queue model.
module tb_limber_gnrl_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  limber_gnrl_fifo_if #(.DW(8)) a_if ();
  limber_gnrl_fifo_if #(.DW(8)) b_if ();

  limber_gnrl_fifo #(.DP(4), .DW(8)) u_a (.clk(clk), .rst_n(rst_n), .fifo(a_if), .cnt(a_cnt));
  limber_gnrl_fifo #(.DP(3), .DW(8)) u_b (.clk(clk), .rst_n(rst_n), .fifo(b_if), .cnt(b_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected data enters on each modelled push, leaves on each modelled pop.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int mca = 0, mcb = 0, b_pops = 0, b_max = 0;

  always @(negedge clk) begin
    int pa, ua;
    if (!rst_n) begin
      qa.delete();
      mca = 0;
    end else begin
      chk("a_i_rdy", 32'(a_if.i_rdy), 32'(mca != 4));
      chk("a_o_vld", 32'(a_if.o_vld), 32'(mca != 0));
      chk("a_cnt", 32'(a_cnt), 32'(mca));
      if (mca != 0) chk("a_o_dat", 32'(a_if.o_dat), 32'(qa[0]));
      pa = ((mca != 0) && a_if.o_rdy) ? 1 : 0;
      ua = (a_if.i_vld && (mca != 4)) ? 1 : 0;
      if (pa != 0) void'(qa.pop_front());
      if (ua != 0) qa.push_back(a_if.i_dat);
      mca = mca + ua - pa;
    end
  end

  always @(negedge clk) begin
    int pb, ub;
    if (!rst_n) begin
      qb.delete();
      mcb = 0;
    end else begin
      chk("b_i_rdy", 32'(b_if.i_rdy), 32'(mcb != 3));
      chk("b_o_vld", 32'(b_if.o_vld), 32'(mcb != 0));
      chk("b_cnt", 32'(b_cnt), 32'(mcb));
      if (mcb != 0) chk("b_o_dat", 32'(b_if.o_dat), 32'(qb[0]));
      if (int'(b_cnt) > b_max) b_max = int'(b_cnt);
      pb = ((mcb != 0) && b_if.o_rdy) ? 1 : 0;
      ub = (b_if.i_vld && (mcb != 3)) ? 1 : 0;
      if (pb != 0) begin
        void'(qb.pop_front());
        b_pops++;
      end
      if (ub != 0) qb.push_back(b_if.i_dat);
      mcb = mcb + ub - pb;
    end
  end

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    a_if.i_vld = 1'b0; a_if.i_dat = '0; a_if.o_rdy = 1'b0;
    b_if.i_vld = 1'b0; b_if.i_dat = '0; b_if.o_rdy = 1'b0;
    repeat (3) step();
    chk("rst_i_rdy", 32'(a_if.i_rdy), 32'd1);
    chk("rst_o_vld", 32'(a_if.o_vld), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    rst_n = 1'b1;

    // Fill to full, then a fifth push held against i_rdy=0.
    for (int i = 0; i < 4; i++) begin
      a_if.i_vld = 1'b1; a_if.i_dat = fill[i];
      step();
    end
    chk("fill_cnt", 32'(a_cnt), 32'd4);
    chk("fill_i_rdy", 32'(a_if.i_rdy), 32'd0);
    a_if.i_dat = 8'hAA;
    repeat (2) step();
    chk("full_ignore_cnt", 32'(a_cnt), 32'd4);
    chk("full_head", 32'(a_if.o_dat), 32'h11);

    // Push and pop together at full: pop only.
    a_if.o_rdy = 1'b1;
    step();
    chk("fullpp_cnt", 32'(a_cnt), 32'd3);
    chk("fullpp_i_rdy", 32'(a_if.i_rdy), 32'd1);
    chk("fullpp_head", 32'(a_if.o_dat), 32'h22);
    a_if.o_rdy = 1'b0;
    step();
    chk("aa_accept_cnt", 32'(a_cnt), 32'd4);
    a_if.i_vld = 1'b0;
    a_if.o_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_cnt", 32'(a_cnt), 32'(3 - k));
    end
    chk("drain_o_vld", 32'(a_if.o_vld), 32'd0);

    // Streaming at occupancy 2 across pointer wrap.
    a_if.o_rdy = 1'b0;
    a_if.i_vld = 1'b1; a_if.i_dat = 8'hE0; step();
    a_if.i_dat = 8'hE1; step();
    a_if.o_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_if.i_dat = 8'(i);
      step();
      chk("stream_cnt", 32'(a_cnt), 32'd2);
    end
    chk("stream_tail_head", 32'(a_if.o_dat), 32'h12);
    a_if.i_vld = 1'b0;
    repeat (2) step();
    chk("stream_end_cnt", 32'(a_cnt), 32'd0);

    // Empty FIFO: no bypass.
    a_if.i_vld = 1'b1; a_if.i_dat = 8'h5A;
    chk("nobyp_o_vld0", 32'(a_if.o_vld), 32'd0);
    step();
    a_if.i_vld = 1'b0;
    chk("nobyp_o_vld1", 32'(a_if.o_vld), 32'd1);
    chk("nobyp_o_dat", 32'(a_if.o_dat), 32'h5A);
    step();
    chk("nobyp_popped", 32'(a_if.o_vld), 32'd0);

    // Asynchronous reset with two entries stored.
    a_if.o_rdy = 1'b0;
    a_if.i_vld = 1'b1; a_if.i_dat = 8'hC1; step();
    a_if.i_dat = 8'hC2; step();
    a_if.i_vld = 1'b0;
    chk("prerst_cnt", 32'(a_cnt), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_o_vld", 32'(a_if.o_vld), 32'd0);
    chk("arst_i_rdy", 32'(a_if.i_rdy), 32'd1);
    chk("arst_cnt", 32'(a_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    a_if.i_vld = 1'b1; a_if.i_dat = 8'h77; step();
    a_if.i_vld = 1'b0;
    chk("postrst_o_vld", 32'(a_if.o_vld), 32'd1);
    chk("postrst_o_dat", 32'(a_if.o_dat), 32'h77);
    chk("postrst_cnt", 32'(a_cnt), 32'd1);
    a_if.o_rdy = 1'b1; step();
    chk("postrst_empty", 32'(a_cnt), 32'd0);
    a_if.o_rdy = 1'b0;

    // DP=3: ten entries with producer and consumer stalls.
    fork
      begin
        logic acc;
        int   g;
        for (int k = 0; k < 10; k++) begin
          b_if.i_vld = 1'b1; b_if.i_dat = 8'h30 + 8'(k);
          g = 0;
          do begin
            @(negedge clk);
            acc = b_if.i_rdy;
            step();
            g++;
          end while (!acc && g < 60);
          if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL b_push_timeout: item %0d not accepted, expected acceptance", k);
            break;
          end
          if (k >= 2 && $urandom_range(0, 1) == 1) begin
            b_if.i_vld = 1'b0;
            repeat ($urandom_range(1, 2)) step();
          end
        end
        b_if.i_vld = 1'b0;
      end
      begin
        b_if.o_rdy = 1'b0;
        repeat (6) step();
        repeat (30) begin
          b_if.o_rdy = 1'($urandom_range(0, 1));
          step();
        end
        b_if.o_rdy = 1'b1;
      end
    join
    repeat (5) step();
    chk("b_pops", 32'(b_pops), 32'd10);
    chk("b_max_cnt", 32'(b_max), 32'd3);
    chk("b_final_cnt", 32'(b_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
